// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, data width and the baud divider
// helper used by both the receiver and the transmitter.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_e;

    function automatic int clks_per_baud(input int clk_rate, input int baud_rate);
        return clk_rate / baud_rate;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs; the reset value lets an
// idle-high line come out of reset without a false edge.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit start validation, centre sampling of each data bit,
// and a single-entry valid/ready output buffer with framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_RATE  = 100_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 rxd_in,
    input  logic                 data_read_ready,
    output logic                 data_read_valid,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 frame_error,
    output logic                 overrun
);

    localparam int CLKS_PER_BAUD = int'(clks_per_baud(CLK_RATE, BAUD_RATE));
    localparam int HALF_BAUD     = CLKS_PER_BAUD / 2;
    localparam int CNT_W         = $clog2(CLKS_PER_BAUD);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BAUD - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BAUD - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    generate
        if (CLKS_PER_BAUD < 4) begin : g_baud_chk
            $error("uart_rx: CLKS_PER_BAUD must be >= 4");
        end
    endgenerate

    logic rxd_s;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk_i (clk),
        .rst_i (areset),
        .d_i   (rxd_in),
        .q_o   (rxd_s)
    );

    uart_state_e          state_q,   state_d;
    logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic [DATA_BITS-1:0] data_q,    data_d;
    logic                 valid_q,   valid_d;
    logic                 ferr_q,    ferr_d;
    logic                 ovr_q,     ovr_d;
    logic                 cnt_zero;

    assign cnt_zero = (clk_cnt_q == '0);

    always_ff @(posedge clk) begin
        if (areset) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            IDLE:    if (!rxd_s) state_d = START;
            START:   if (cnt_zero) state_d = rxd_s ? IDLE : DATA;
            DATA:    if (cnt_zero && bit_cnt_q == LAST_BIT) state_d = STOP;
            STOP:    if (cnt_zero) state_d = rxd_s ? IDLE : BREAK;
            BREAK:   if (rxd_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : datapath
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q & ~data_read_ready;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rxd_s) clk_cnt_d = CNT_HALF;
            end
            START: begin
                if (cnt_zero) begin
                    clk_cnt_d = CNT_FULL;
                    bit_cnt_d = '0;
                end else begin
                    clk_cnt_d = clk_cnt_q - CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_zero) begin
                    shift_d   = {rxd_s, shift_q[DATA_BITS-1:1]};
                    clk_cnt_d = CNT_FULL;
                    if (bit_cnt_q != LAST_BIT) bit_cnt_d = bit_cnt_q + 3'd1;
                end else begin
                    clk_cnt_d = clk_cnt_q - CNT_W'(1);
                end
            end
            STOP: begin
                if (!cnt_zero) begin
                    clk_cnt_d = clk_cnt_q - CNT_W'(1);
                end else if (!rxd_s) begin
                    ferr_d = 1'b1;
                end else if (!valid_q || data_read_ready) begin
                    // buffer is free, or is being drained on this very edge
                    data_d  = shift_q;
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign data_read_valid = valid_q;
    assign data_out        = data_q;
    assign frame_error     = ferr_q;
    assign overrun         = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomised and directed bench for uart_rx at 10 clocks per bit, checked against a
// frame-level reference model (expected byte queue and error/overrun counts).
module tb_uart_rx;

    localparam int CLK_RATE  = 100_000_000;
    localparam int BAUD_RATE = 10_000_000;
    localparam int CPB       = 10;

    logic       clk             = 1'b0;
    logic       areset          = 1'b1;
    logic       rxd_in          = 1'b1;
    logic       data_read_ready = 1'b0;
    logic       data_read_valid;
    logic [7:0] data_out;
    logic       frame_error;
    logic       overrun;

    uart_rx #(
        .CLK_RATE  (CLK_RATE),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk             (clk),
        .areset          (areset),
        .rxd_in          (rxd_in),
        .data_read_ready (data_read_ready),
        .data_read_valid (data_read_valid),
        .data_out        (data_out),
        .frame_error     (frame_error),
        .overrun         (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Observed transactions, sampled on the falling edge.
    logic [7:0] rx_q[$];
    int   ferr_cnt = 0, ovr_cnt = 0, both_cnt = 0, vld_cyc = 0, t_vld = 0, t_start = 0;
    logic vld_prev = 1'b0;

    always @(negedge clk) begin
        if (data_read_valid === 1'b1) vld_cyc++;
        if (data_read_valid === 1'b1 && !vld_prev) t_vld = cyc;
        if (data_read_valid === 1'b1 && data_read_ready) rx_q.push_back(data_out);
        if (frame_error === 1'b1) ferr_cnt++;
        if (overrun === 1'b1) ovr_cnt++;
        if (frame_error === 1'b1 && overrun === 1'b1) both_cnt++;
        vld_prev = (data_read_valid === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rxd_in  = 1'b0;
        t_start = cyc;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd_in = b[i];
            tick(CPB);
        end
        rxd_in = stop;
        tick(CPB);
    endtask

    task automatic chk_byte(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        got = 8'hxx;
        if (rx_q.size() > 0) got = rx_q.pop_front();
        chk(tag, 32'(got), 32'(exp));
    endtask

    logic [7:0] exp_q[$];
    logic [7:0] b2b[4];
    logic [7:0] rb;
    logic       rok;
    logic       rand_rdy;
    int         v0, f0, o0, f_exp, gap;

    initial begin
        tick(3);
        chk("rst_valid", 32'(data_read_valid), 32'd0);
        chk("rst_data",  32'(data_out),        32'h00);
        chk("rst_ferr",  32'(frame_error),     32'd0);
        chk("rst_ovr",   32'(overrun),         32'd0);
        areset = 1'b0;
        tick(5);

        // single frame, consumer always ready
        data_read_ready = 1'b1;
        v0 = vld_cyc;
        send_frame(8'hA5, 1'b1);
        tick(20);
        chk("a5_latency", 32'(t_vld - t_start), 32'd98);
        chk("a5_width",   32'(vld_cyc - v0),    32'd1);
        chk_byte("a5_data", 8'hA5);
        chk("a5_extra", 32'(rx_q.size()), 32'd0);

        // overrun: second byte dropped, first kept
        data_read_ready = 1'b0;
        o0 = ovr_cnt;
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        tick(5);
        chk("ovr_data",   32'(data_out),        32'h3C);
        chk("ovr_valid",  32'(data_read_valid), 32'd1);
        chk("ovr_pulse",  32'(ovr_cnt - o0),    32'd1);
        chk("ovr_unread", 32'(rx_q.size()),     32'd0);
        data_read_ready = 1'b1;
        tick(3);
        chk("ovr_drop_valid", 32'(data_read_valid), 32'd0);
        chk_byte("ovr_first", 8'h3C);
        tick(20);
        chk("ovr_no_second", 32'(rx_q.size()), 32'd0);

        // framing error followed by a long break
        f0 = ferr_cnt;
        v0 = vld_cyc;
        send_frame(8'h55, 1'b0);
        tick(30 * CPB);
        rxd_in = 1'b1;
        tick(2 * CPB);
        chk("ferr_pulse", 32'(ferr_cnt - f0), 32'd1);
        chk("ferr_novld", 32'(vld_cyc - v0),  32'd0);
        send_frame(8'h0F, 1'b1);
        tick(20);
        chk_byte("ferr_next", 8'h0F);

        // false start
        f0 = ferr_cnt;
        v0 = vld_cyc;
        rxd_in = 1'b0;
        tick(3);
        rxd_in = 1'b1;
        tick(3 * CPB);
        chk("glitch_novld", 32'(vld_cyc - v0),  32'd0);
        chk("glitch_noerr", 32'(ferr_cnt - f0), 32'd0);
        send_frame(8'h81, 1'b1);
        tick(20);
        chk_byte("glitch_next", 8'h81);

        // reset mid-frame with a byte still buffered
        data_read_ready = 1'b0;
        send_frame(8'h77, 1'b1);
        tick(20);
        chk("rst_pre_valid", 32'(data_read_valid), 32'd1);
        rxd_in = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rxd_in = 1'b1;
            tick(CPB);
        end
        tick(5);
        areset = 1'b1;
        tick(1);
        areset = 1'b0;
        chk("mid_rst_valid", 32'(data_read_valid), 32'd0);
        chk("mid_rst_data",  32'(data_out),        32'h00);
        chk("mid_rst_ferr",  32'(frame_error),     32'd0);
        chk("mid_rst_ovr",   32'(overrun),         32'd0);
        data_read_ready = 1'b1;
        tick(15 * CPB);
        chk("mid_rst_nobyte", 32'(rx_q.size()), 32'd0);
        send_frame(8'h12, 1'b1);
        tick(20);
        chk_byte("mid_rst_next", 8'h12);

        // back-to-back frames
        b2b = '{8'h00, 8'hFF, 8'h01, 8'h80};
        o0 = ovr_cnt;
        f0 = ferr_cnt;
        for (int i = 0; i < 4; i++) send_frame(b2b[i], 1'b1);
        tick(20);
        for (int i = 0; i < 4; i++) chk_byte("b2b_data", b2b[i]);
        chk("b2b_ovr",  32'(ovr_cnt - o0),  32'd0);
        chk("b2b_ferr", 32'(ferr_cnt - f0), 32'd0);

        // random frames, random gaps, random consumer stalls
        o0 = ovr_cnt;
        f0 = ferr_cnt;
        f_exp = 0;
        rand_rdy = 1'b1;
        fork
            begin
                while (rand_rdy) begin
                    data_read_ready = ($urandom_range(0, 3) == 0);
                    tick(1);
                end
            end
        join_none
        for (int k = 0; k < 24; k++) begin
            rb  = 8'($urandom);
            rok = ($urandom_range(0, 4) != 0);
            send_frame(rb, rok);
            if (rok) begin
                exp_q.push_back(rb);
            end else begin
                f_exp++;
                tick(CPB * int'($urandom_range(0, 3)) + 1);
                rxd_in = 1'b1;
                tick(CPB);
            end
            gap = int'($urandom_range(0, 2));
            if (gap > 0) tick(gap * CPB);
        end
        rand_rdy = 1'b0;
        tick(3);
        data_read_ready = 1'b1;
        tick(3 * CPB);
        chk("rnd_count", 32'(rx_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0) chk_byte("rnd_data", exp_q.pop_front());
        chk("rnd_ferr", 32'(ferr_cnt - f0), 32'(f_exp));
        chk("rnd_ovr",  32'(ovr_cnt - o0),  32'd0);
        chk("flags_exclusive", 32'(both_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver for 8N1 serial frames: 1 start bit (low), 8 data bits LSB-first, 1 stop bit (high); the idle line is high.
- Synchronises the asynchronous rxd_in line and validates the start bit at mid-bit.
- Samples each data bit at its centre and delivers each byte through a one-entry valid/ready output buffer.
- Pairs with the UART transmitter at the far end of the serial link; flags framing errors and overruns.

Parameters:
- CLK_RATE, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 115_200, serial bit rate in bits/s.
- Derived: CLKS_PER_BAUD = int'(CLK_RATE/BAUD_RATE); HALF_BAUD = CLKS_PER_BAUD/2.
- CLKS_PER_BAUD must be >= 4; elaboration-time assertion.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- areset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- rxd_in  in  1  asynchronous serial input; idle high.
- data_read_ready  in  1  consumer accepts data_out this cycle.
- data_read_valid  out  1  data_out holds an unread byte.
- data_out  out  8  received byte; bit 0 was the first data bit on the wire.
- frame_error  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: complete frame dropped because the buffer was full.

Behaviour:
- Reset (areset high at a clock edge):
  - synchroniser flops <= 1; state <= IDLE; counters <= 0.
  - data_read_valid = 0, data_out = 8'h00, frame_error = 0, overrun = 0.
  - Reset mid-frame abandons the frame; a buffered byte is discarded.
- Synchroniser: 2 flops; rxd_s is the second flop. All decisions use rxd_s only; 2-cycle input latency.
- Counter conventions: clk_cnt counts down; a sample is taken in the cycle clk_cnt == 0. bit_cnt is 3 bits.
- States:
  - IDLE: if rxd_s == 0, go START and load clk_cnt <= HALF_BAUD-1.
  - START: at clk_cnt == 0, sample rxd_s.
    - If 0: go DATA, clk_cnt <= CLKS_PER_BAUD-1, bit_cnt <= 0.
    - If 1 (glitch / false start): go IDLE; no flag.
  - DATA: at clk_cnt == 0, shift_reg <= {rxd_s, shift_reg[7:1]} and reload clk_cnt <= CLKS_PER_BAUD-1.
    - After the 8th sample (bit_cnt == 7), go STOP; otherwise bit_cnt++.
  - STOP: at clk_cnt == 0, sample rxd_s.
    - If 1: deliver the byte (rules below), then go IDLE.
    - If 0: pulse frame_error for the next cycle, discard the byte, go BREAK.
  - BREAK: wait until rxd_s == 1, then go IDLE. A held-low line (break condition) must not retrigger reception.
- Sampling points: nominally mid-bit, at HALF_BAUD + k*CLKS_PER_BAUD cycles after rxd_s first reads 0.
- Delivery, in the cycle after the stop sample:
  - If data_read_valid == 0, or a handshake (valid & ready) occurs in the same cycle as the stop sample: data_out <= byte, data_read_valid <= 1.
  - Otherwise: the old byte is kept, the new byte is dropped, and overrun pulses for one cycle.
- Handshake:
  - data_read_valid drops in the cycle after valid & ready unless a new byte is loaded in that same edge.
  - data_out is stable while valid is high and not yet accepted.
- Back-to-back frames: a start bit immediately after the stop sample (STOP -> IDLE -> START) is received without loss.
- frame_error and overrun never assert in the same cycle.

Decomposition:
- Shared package uart_pkg:
  - state enum {IDLE, START, DATA, STOP, BREAK};
  - DATA_BITS = 8;
  - function clks_per_baud(clk_rate, baud_rate), shared with the transmitter.
- Sub-module sync_2ff: generic 2-flop synchroniser with a RESET_VAL parameter (1 here); reusable across the codebase.

Test Plan:
- CLK_RATE=100_000_000, BAUD_RATE=10_000_000 (CLKS_PER_BAUD=10):
  - Drive byte 8'hA5 with data_read_ready held high.
  - Required: data_read_valid pulses for 1 cycle with data_out = 8'hA5, 2 + 5 + 8*10 + 10 + 1 = 98 cycles after the start falling edge.
- Hold data_read_ready low; send 8'h3C then 8'hC3.
  - Required: data_out stays 8'h3C; overrun pulses once after the second stop bit.
  - Then assert ready: valid drops and no second byte appears.
- Send 8'h55 with the stop bit driven low, then hold the line low for 30 bit times.
  - Required: one frame_error pulse; no valid.
  - After the line returns high, 8'h0F is received correctly.
- Drive a 3-cycle low glitch on rxd_in.
  - Required: no valid, no frame_error; the next frame 8'h81 is received.
- Assert areset midway through the data bits of 8'hFF.
  - Required: all outputs 0 the cycle after; the following frame 8'h12 is received correctly.
- Send 4 back-to-back frames (8'h00, 8'hFF, 8'h01, 8'h80) with ready high.
  - Required: all 4 are delivered in order; no overrun or frame_error.
